div_issue_ctrl: RTL and testbench

- Execute-stage front end for the multi-cycle divider.
- Accepts a DIV.W/MOD.W/DIV.WU/MOD.WU request from EX, launches the divider with a one-cycle start pulse, and holds operands stable while the divider runs.
- Selects the quotient or remainder and holds the result until EX hands the instruction forward.
- Handles divide-by-zero locally and absorbs pipeline flushes that arrive while a divide is still in flight.

---
 rtl/div_issue_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage front end for the multi-cycle divider.
// It launches the divider with a one-cycle start pulse and keeps the
// operands stable while the divider runs. It picks the quotient or the
// remainder and holds that result until EX moves the instruction on.
// A divide by zero is answered locally without starting the divider.
// A flush that arrives while a divide is still running is absorbed by
// letting the divider finish and throwing its result away.
module div_issue_ctrl #(
  parameter logic [31:0] DIVZERO_Q      = 32'hFFFF_FFFF,
  parameter bit          DIVZERO_R_IS_X = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  // request from EX
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_accept,
  input  logic        flush,
  // divider interface
  output logic        div,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  // result to EX
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        busy
);

  // Opcode bit 1 selects an unsigned divide; bit 0 selects the remainder.
  localparam int OP_UNSIGNED_BIT = 1;
  localparam int OP_REM_BIT      = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request
    BUSY  = 2'd1,  // divider running for a live instruction
    DRAIN = 2'd2,  // divider running for a flushed instruction
    DONE  = 2'd3   // result held for EX
  } state_t;

  state_t      state;
  state_t      next_state;

  // Control decoded from the current state and the inputs
  logic        launch;     // start the divider on this edge
  logic        zero_done;  // answer a divide by zero on this edge
  logic        capture;    // take the divider result on this edge

  // Operand and result registers
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic        signed_q;
  logic        rem_sel_q;
  logic        div_q;
  logic [31:0] res_q;

  logic        req_is_zero;
  logic [31:0] zero_result;
  logic [31:0] div_result;

  assign req_is_zero = (req_src2 == 32'd0);

  // Result for a divide by zero. DIV returns the fixed quotient. MOD returns
  // either the dividend or zero, depending on the parameter.
  assign zero_result = req_op[OP_REM_BIT]
                     ? (DIVZERO_R_IS_X ? req_src1 : 32'd0)
                     : DIVZERO_Q;

  // The divider output, overflow cases included, goes through unchanged.
  assign div_result = rem_sel_q ? div_r : div_s;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: Sequential state always uses non-blocking assignment. Every
    // register then samples values from before the edge, so the order in
    // which the always blocks run does not matter.
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-edge control strobes. flush is tested first.
  always_comb begin
    // NOTE: Every output of this block is given a default before the case
    // statement. Without the defaults, a path that misses an assignment
    // would infer a latch.
    next_state = state;
    launch     = 1'b0;
    zero_done  = 1'b0;
    capture    = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          if (req_is_zero) begin
            zero_done  = 1'b1;
            next_state = DONE;
          end else begin
            launch     = 1'b1;
            next_state = BUSY;
          end
        end
      end

      BUSY: begin
        if (flush) begin
          // The divider is started and cannot be stopped. If it finishes
          // on this edge, return to IDLE. Otherwise wait in DRAIN.
          next_state = div_complete ? IDLE : DRAIN;
        end else if (div_complete) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end

      DRAIN: begin
        // New requests wait here until the divider is free again.
        if (div_complete) begin
          next_state = IDLE;
        end
      end

      DONE: begin
        if (flush || req_accept) begin
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // Operand registers are loaded only on the launch edge. The divider then
  // sees stable inputs for the whole divide, even if EX changes its sources.
  always_ff @(posedge clk) begin
    // NOTE: These datapath registers get a reset value so that the divider
    // inputs read 0 after reset. The only cost is a reset on a few flops.
    if (!resetn) begin
      x_q       <= 32'd0;
      y_q       <= 32'd0;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (launch) begin
      x_q       <= req_src1;
      y_q       <= req_src2;
      signed_q  <= ~req_op[OP_UNSIGNED_BIT];
      rem_sel_q <= req_op[OP_REM_BIT];
    end
  end

  // Registered start pulse. It is high only in the cycle after launch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q <= 1'b0;
    end else begin
      div_q <= launch;
    end
  end

  // Result register. It is written by a divide-by-zero answer or by a
  // divider completion, and otherwise holds its value while EX is stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      res_q <= 32'd0;
    end else if (zero_done) begin
      res_q <= zero_result;
    end else if (capture) begin
      res_q <= div_result;
    end
  end

  assign div        = div_q;
  assign div_signed = signed_q;
  assign div_x      = x_q;
  assign div_y      = y_q;
  assign res_data   = res_q;
  assign res_valid  = (state == DONE);
  assign busy       = (state == BUSY) || (state == DRAIN);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl. A behavioural divider answers each start
// pulse after a fixed latency. The expected results are queued when a
// request is driven and are compared when res_valid rises.
module tb_div_issue_ctrl;

  localparam int DIV_LAT = 6;
  localparam int TIMEOUT = 60;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_accept;
  logic        flush;
  logic        div;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;
  logic        res_valid;
  logic [31:0] res_data;
  logic        busy;

  int          n_checks;
  int          n_fail;
  int          pulses;
  logic [31:0] exp_q[$];

  div_issue_ctrl #(
    .DIVZERO_Q      (32'hFFFF_FFFF),
    .DIVZERO_R_IS_X (1'b1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .req_accept   (req_accept),
    .flush        (flush),
    .div          (div),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference division. Signed overflow gives the dividend as the quotient
  // and zero as the remainder.
  function automatic void ref_div(input logic sgn, input logic [31:0] x,
                                  input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = x;
        r = 32'd0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  function automatic logic [31:0] exp_result(input logic [1:0] op,
                                             input logic [31:0] s1,
                                             input logic [31:0] s2);
    logic [31:0] q;
    logic [31:0] r;
    if (s2 == 32'd0) return op[0] ? s1 : 32'hFFFF_FFFF;
    ref_div(~op[1], s1, s2, q, r);
    return op[0] ? r : q;
  endfunction

  // Behavioural divider. It samples the operands on the start pulse and
  // raises div_complete for one cycle DIV_LAT cycles later.
  int          dcnt;
  logic        d_sgn;
  logic [31:0] d_x;
  logic [31:0] d_y;
  always @(posedge clk) begin
    if (!resetn) begin
      dcnt         <= 0;
      div_complete <= 1'b0;
      div_s        <= 32'd0;
      div_r        <= 32'd0;
    end else begin
      div_complete <= 1'b0;
      if (div) begin
        dcnt  <= DIV_LAT;
        d_sgn <= div_signed;
        d_x   <= div_x;
        d_y   <= div_y;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          logic [31:0] q;
          logic [31:0] r;
          ref_div(d_sgn, d_x, d_y, q, r);
          div_s        <= q;
          div_r        <= r;
          div_complete <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) if (div === 1'b1) pulses <= pulses + 1;

  // Drives a request and advances to the next negedge. With a non-zero
  // divisor, the start pulse must be visible by then.
  task automatic start_req(input logic [1:0] op, input logic [31:0] s1,
                           input logic [31:0] s2, input bit expect_res);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    if (expect_res) exp_q.push_back(exp_result(op, s1, s2));
    @(negedge clk);
    if (s2 != 32'd0) begin
      n_checks++;
      if (div !== 1'b1 || busy !== 1'b1 || div_signed !== ~op[1]) begin
        n_fail++;
        $display("FAIL launch op=%0d: div=%b busy=%b signed=%b, want 1 1 %b",
                 op, div, busy, div_signed, ~op[1]);
      end
    end
  endtask

  task automatic wait_result(input string name);
    int          n = 0;
    logic [31:0] e;
    while (res_valid !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: res_valid timeout after %0d cycles", name, n);
    end else if (res_data !== e) begin
      n_fail++;
      $display("FAIL %s: res_data=%h want %h", name, res_data, e);
    end
  endtask

  task automatic accept_res(input string name);
    req_accept = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    req_accept = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: res_valid=%b busy=%b want 0 0", name, res_valid, busy);
    end
  endtask

  task automatic wait_complete(input string name);
    int n = 0;
    while (div_complete !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (div_complete !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: div_complete timeout got %b want 1", name, div_complete);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({div, res_valid, busy, div_signed} !== 4'b0 || res_data !== 32'd0 ||
        div_x !== 32'd0 || div_y !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: div=%b rv=%b busy=%b sgn=%b res=%h x=%h y=%h want all 0",
               div, res_valid, busy, div_signed, res_data, div_x, div_y);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_div_w();
    int p0 = pulses;
    start_req(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_complete("div_w");
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL div_w latency: res_valid=%b want 1", res_valid);
    end
    wait_result("div_w");
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFD) begin
        n_fail++;
        $display("FAIL div_w hold: rv=%b res=%h want 1 fffffffd", res_valid, res_data);
      end
    end
    n_checks++;
    if (pulses - p0 !== 1) begin
      n_fail++;
      $display("FAIL div_w pulses: got %0d want 1", pulses - p0);
    end
    accept_res("div_w");
  endtask

  task automatic test_modwu_stable();
    bit moved = 0;
    int n = 0;
    start_req(2'b11, 32'hFFFF_FFFF, 32'd10, 1'b1);
    while (busy === 1'b1 && n < TIMEOUT) begin
      req_src1 = $urandom;
      req_src2 = $urandom;
      @(negedge clk);
      n++;
      if (busy === 1'b1 && (div_x !== 32'hFFFF_FFFF || div_y !== 32'd10 ||
                            div_signed !== 1'b0)) moved = 1;
    end
    n_checks++;
    if (moved) begin
      n_fail++;
      $display("FAIL modwu operands: x=%h y=%h sgn=%b want ffffffff 0000000a 0",
               div_x, div_y, div_signed);
    end
    wait_result("modwu");
    accept_res("modwu");
  endtask

  task automatic test_divzero();
    int p0 = pulses;
    start_req(2'b00, 32'h55, 32'd0, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL divzero latency: res_valid=%b want 1", res_valid);
    end
    wait_result("div_w_zero");
    accept_res("div_w_zero");
    start_req(2'b01, 32'h1234, 32'd0, 1'b1);
    wait_result("mod_w_zero");
    accept_res("mod_w_zero");
    n_checks++;
    if (pulses !== p0) begin
      n_fail++;
      $display("FAIL divzero pulses: got %0d want 0", pulses - p0);
    end
  endtask

  task automatic test_flush_drain();
    int p1;
    int n = 0;
    bit leak = 0;
    start_req(2'b10, 32'd77, 32'd5, 1'b0);
    repeat (2) @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain entry: busy=%b rv=%b want 1 0", busy, res_valid);
    end
    p1 = pulses;
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_src1  = 32'd1000;
    req_src2  = 32'd3;
    exp_q.push_back(exp_result(2'b10, 32'd1000, 32'd3));
    while (busy === 1'b1 && n < TIMEOUT) begin
      if (res_valid !== 1'b0) leak = 1;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (leak || pulses !== p1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: leak=%b pulses=%0d busy=%b rv=%b want 0 0 0 0",
               leak, pulses - p1, busy, res_valid);
    end
    @(negedge clk);
    n_checks++;
    if (div !== 1'b1) begin
      n_fail++;
      $display("FAIL drain relaunch: div=%b want 1", div);
    end
    wait_result("after_drain");
    accept_res("after_drain");
  endtask

  task automatic test_flush_complete();
    bit leak = 0;
    start_req(2'b00, 32'd100, 32'd7, 1'b0);
    wait_complete("flush_cmp");
    flush     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) begin
      if (res_valid !== 1'b0 || busy !== 1'b0) leak = 1;
      @(negedge clk);
    end
    n_checks++;
    if (leak) begin
      n_fail++;
      $display("FAIL flush_cmp: rv=%b busy=%b want 0 0", res_valid, busy);
    end
    start_req(2'b00, 32'd5, 32'd0, 1'b1);
    wait_result("flush_done");
    flush     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: rv=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset_busy();
    start_req(2'b10, 32'd50, 32'd5, 1'b0);
    @(negedge clk);
    resetn    = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({div, res_valid, busy, div_signed} !== 4'b0 || res_data !== 32'd0 ||
        div_x !== 32'd0 || div_y !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_busy: div=%b rv=%b busy=%b sgn=%b res=%h x=%h y=%h want all 0",
               div, res_valid, busy, div_signed, res_data, div_x, div_y);
    end
    resetn = 1'b1;
    repeat (DIV_LAT + 3) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy idle: rv=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit moved = 0;
    start_req(2'b10, 32'd100, 32'd7, 1'b1);
    wait_result("backpressure");
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 32'd14) moved = 1;
    end
    n_checks++;
    if (moved) begin
      n_fail++;
      $display("FAIL backpressure hold: rv=%b res=%h want 1 0000000e", res_valid, res_data);
    end
    accept_res("backpressure");
    start_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("overflow");
    accept_res("overflow");
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d results left, want 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    pulses     = 0;
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_src1   = 32'd0;
    req_src2   = 32'd0;
    req_accept = 1'b0;
    flush      = 1'b0;
    test_reset();
    test_div_w();
    test_modwu_stable();
    test_divzero();
    test_flush_drain();
    test_flush_complete();
    test_reset_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
